pipelined_csel_adder: RTL
=========================

// Module: pipelined_csel_adder
// PURPOSE
//  Parametrised, pipelined carry-select adder/subtractor with valid/ready handshake.
//  Successor to the fixed-width combinational adders: WIDTH bits split into SEG-bit carry-select segments.
//  Segments are spread across STAGES register stages, with the carry registered between stages.
//  Sits in front of the SLC3-GPU ALU/address paths, where WIDTH-bit adds must close timing at full clock.
// PARAMETERS
//  WIDTH   16  operand/result width in bits
//  SEG     4   carry-select segment width; WIDTH % SEG == 0
//  STAGES  2   pipeline stages (= latency); (WIDTH/SEG) % STAGES == 0; STAGES >= 1
// PORTS
//  Clk        in   1      clock; all state updates on rising edge
//  Reset      in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat present
//  in_ready   out  1      block can accept a beat this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  Cin        in   1      carry-in (add mode only)
//  sub        in   1      1: A - B = A + ~B + 1 (Cin ignored); 0: A + B + Cin
//  out_valid  out  1      result beat present
//  out_ready  in   1      consumer accepts result this cycle
//  Sum        out  WIDTH  result
//  Cout       out  1      carry out of MSB (sub: 1 = no borrow)
//  Ovf        out  1      signed two's-complement overflow
// BEHAVIOUR
//  - Reset (sync): all stage valid bits clear; out_valid=0, Sum=0, Cout=0, Ovf=0 the cycle after Reset is sampled high.
//  - in_ready=0 while Reset=1. Beats in flight when Reset is asserted are discarded; no partial result is emitted.
//  - Segment s computes both sum_c0 and sum_c1 (two SEG-bit adds) and selects on the incoming carry.
//    Carry ripples combinationally through the segments within a stage.
//  - Stage k (0..STAGES-1) handles segments k*SPS .. (k+1)*SPS-1, where SPS = (WIDTH/SEG)/STAGES.
//    Its carry-out is registered into stage k+1.
//  - Operand skew: upper-segment A/B/sub bits are delayed through registers to reach their stage.
//    Lower-segment results are delayed so all bits of one beat exit together.
//  - Latency: exactly STAGES cycles from in_valid&&in_ready to out_valid, when out_ready stays high.
//  - Throughput: one beat per cycle.
//  - Handshake: transfer on valid&&ready, both sides.
//    Stage i advances when it is empty or stage i+1 advances (bubble-collapsing).
//    in_ready = stage0 advance condition.
//  - Stall: out_valid && !out_ready holds Sum/Cout/Ovf stable until accepted.
//    Upstream stages fill, then in_ready drops. No beat is lost or duplicated.
//  - Simultaneous accept-in and emit-out on a full pipe: allowed; occupancy unchanged.
//  - Ovf = (A_eff[MSB] == B_eff[MSB]) && (Sum_raw[MSB] != A_eff[MSB]), where B_eff = sub ? ~B : B.
//  - Wrap-around: the raw sum is modulo 2^WIDTH; Cout carries bit WIDTH.
//  - sub, Cin, A and B are sampled only on the accepting edge. Changes while in_ready=0 are ignored.
// CONFIGURATION
//  PIPE_ADD_SAT_EN defined: on Ovf, Sum clamps to signed max (0111..1) when A_eff[MSB]=0.
//    It clamps to signed min (1000..0) otherwise. Ovf and Cout still report the raw values.
//    The clamp mux lives in the final stage; latency is unchanged.
//  PIPE_ADD_SAT_EN undefined: Sum = raw wrapped sum; no clamp logic is present.
// TESTING
//  1. WIDTH=16,STAGES=2: A=0x1234,B=0x0FFF,Cin=1,sub=0 -> 2 cycles later Sum=0x2234,Cout=0,Ovf=0.
//  2. A=0xFFFF,B=0x0001,sub=0,Cin=0 -> Sum=0x0000,Cout=1,Ovf=0 (carry crosses every segment/stage).
//  3. A=0x7FFF,B=0x0001,sub=0 -> Ovf=1; Sum=0x8000 without PIPE_ADD_SAT_EN, 0x7FFF with it.
//  4. A=0x8000,B=0x0001,sub=1 -> Ovf=1,Cout=1; Sum=0x7FFF, or 0x8000 with PIPE_ADD_SAT_EN.
//  5. Back-to-back 8 beats; out_ready low for 3 cycles mid-stream -> in_ready drops once 2 stages full.
//     All 8 results emerge in order, values correct, no duplicates.
//  6. Reset pulsed 1 cycle with 2 beats in flight -> next cycle out_valid=0, Sum=0.
//     No stale beats emerge; a new beat after reset completes in STAGES cycles.

Source files
------------

// File: rtl/pipelined_csel_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_csel_adder_if
// Description : Operand/result handshake bundle for pipelined_csel_adder.
//               Input side : in_valid/in_ready, A, B, Cin, sub
//               Output side: out_valid/out_ready, Sum, Cout, Ovf
//               master = producer of operands and consumer of results
//               slave  = the adder itself
// Parameters  : WIDTH - operand/result width in bits
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_csel_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_csel_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_csel_adder
// Description : Parametrised pipelined carry-select adder/subtractor with a
//               valid/ready handshake on both sides.
//               WIDTH bits are split into SEG-bit carry-select segments that
//               are spread evenly over STAGES register stages. Inside a stage
//               the carry ripples through the segment muxes; between stages
//               the carry is registered. Latency is STAGES cycles, throughput
//               one beat per cycle.
// Ports       : Clk    - clock, rising edge
//               Reset  - synchronous, active-high; clears all stage valids
//                        and the result registers
//               bus    - pipelined_csel_adder_if.slave
//                        in_valid/in_ready/A/B/Cin/sub   operand beat
//                        out_valid/out_ready/Sum/Cout/Ovf result beat
// Parameters  : WIDTH  - operand/result width (default 16)
//               SEG    - segment width, WIDTH % SEG == 0 (default 4)
//               STAGES - pipeline depth, (WIDTH/SEG) % STAGES == 0 (default 2)
// Build macro : PIPE_ADD_SAT_EN - when defined, Sum saturates to the signed
//               max/min on overflow (Ovf/Cout still report the raw result).
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_csel_adder #(
  parameter int WIDTH  = 16,
  parameter int SEG    = 4,
  parameter int STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  pipelined_csel_adder_if.slave bus
);

  // Segments per stage and bits handled per stage.
  localparam int c_nseg = WIDTH / SEG;
  localparam int c_sps  = c_nseg / STAGES;
  localparam int c_sw   = c_sps * SEG;

  // --------------------------------------------------------------------------
  // Stage occupancy and advance logic
  // --------------------------------------------------------------------------
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_adv;

  // A stage may take a new beat when it is empty or its content moves on
  // this cycle. Evaluated from the output end backwards so a bubble anywhere
  // in the pipe lets the stages behind it close up.
  always_comb begin
    logic v_next_adv;
    w_adv      = '0;
    v_next_adv = bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      v_next_adv = !r_valid[i] || v_next_adv;
      w_adv[i]   = v_next_adv;
    end
  end

  assign bus.in_ready = w_adv[0] && !Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_valid <= '0;
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= bus.in_valid;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_adv[i]) begin
          r_valid[i] <= r_valid[i-1];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-stage datapath inputs
  // Element k is what stage k works on: the full effective operands, the
  // partial sum built so far (bits above the finished segments are zero)
  // and the carry into its lowest segment.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_a_in   [STAGES];
  logic [WIDTH-1:0] w_b_in   [STAGES];
  logic [WIDTH-1:0] w_sum_in [STAGES];
  logic             w_c_in   [STAGES];

  // Subtraction is A + ~B + 1; the operand inversion happens once at entry
  // so every later stage only ever adds.
  assign w_a_in[0]   = bus.A;
  assign w_b_in[0]   = bus.sub ? ~bus.B : bus.B;
  assign w_c_in[0]   = bus.sub ? 1'b1 : bus.Cin;
  assign w_sum_in[0] = '0;

  // Result registers (last stage).
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic             r_out_ovf;

  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.Sum       = r_out_sum;
  assign bus.Cout      = r_out_cout;
  assign bus.Ovf       = r_out_ovf;

  // --------------------------------------------------------------------------
  // Stages
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int c_lo = k * c_sw;

    logic [c_sw-1:0]  w_seg_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum_out;
    logic             w_load;

    // Carry-select segments: each segment forms both candidate sums up
    // front and the incoming carry only steers a mux, so the in-stage
    // critical path is one SEG-bit add plus c_sps mux levels.
    always_comb begin
      logic           v_carry;
      logic [SEG:0]   v_sum_c0;
      logic [SEG:0]   v_sum_c1;
      v_carry   = w_c_in[k];
      w_seg_sum = '0;
      for (int j = 0; j < c_sps; j++) begin
        v_sum_c0 = {1'b0, w_a_in[k][c_lo + j*SEG +: SEG]}
                 + {1'b0, w_b_in[k][c_lo + j*SEG +: SEG]};
        v_sum_c1 = {1'b0, w_a_in[k][c_lo + j*SEG +: SEG]}
                 + {1'b0, w_b_in[k][c_lo + j*SEG +: SEG]}
                 + (SEG+1)'(1);
        w_seg_sum[j*SEG +: SEG] = v_carry ? v_sum_c1[SEG-1:0] : v_sum_c0[SEG-1:0];
        v_carry                 = v_carry ? v_sum_c1[SEG]     : v_sum_c0[SEG];
      end
      w_cout = v_carry;
    end

    // Bits at and above this stage's window are still zero in w_sum_in,
    // so OR-ing the new window in is enough.
    assign w_sum_out = w_sum_in[k] | (WIDTH'(w_seg_sum) << c_lo);

    // Data registers only capture real beats; bubbles leave them untouched
    // so Sum does not wander while out_valid is low.
    if (k == 0) begin : g_load_first
      assign w_load = w_adv[k] && bus.in_valid;
    end else begin : g_load_next
      assign w_load = w_adv[k] && r_valid[k-1];
    end

    if (k < STAGES - 1) begin : g_mid
      // Skew registers: carry the untouched upper operand bits forward and
      // hold the finished lower result bits until the beat exits.
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_sum;
      logic             r_carry;

      always_ff @(posedge Clk) begin
        if (w_load) begin
          r_a     <= w_a_in[k];
          r_b     <= w_b_in[k];
          r_sum   <= w_sum_out;
          r_carry <= w_cout;
        end
      end

      assign w_a_in[k+1]   = r_a;
      assign w_b_in[k+1]   = r_b;
      assign w_sum_in[k+1] = r_sum;
      assign w_c_in[k+1]   = r_carry;
    end else begin : g_last
      logic             w_ovf;
      logic             w_a_msb;
      logic [WIDTH-1:0] w_final;

      assign w_a_msb = w_a_in[k][WIDTH-1];

      // Overflow: operands agree in sign but the raw result does not.
      assign w_ovf = (w_a_msb == w_b_in[k][WIDTH-1])
                  && (w_sum_out[WIDTH-1] != w_a_msb);

`ifdef PIPE_ADD_SAT_EN
      // Positive operands overflow upwards, negative ones downwards.
      assign w_final = !w_ovf  ? w_sum_out :
                       w_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} :
                                 {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign w_final = w_sum_out;
`endif

      always_ff @(posedge Clk) begin
        if (Reset) begin
          r_out_sum  <= '0;
          r_out_cout <= 1'b0;
          r_out_ovf  <= 1'b0;
        end else if (w_load) begin
          r_out_sum  <= w_final;
          r_out_cout <= w_cout;
          r_out_ovf  <= w_ovf;
        end
      end
    end
  end

endmodule
`default_nettype wire
